// File: rtl/aes_pkg.sv
// Shared types and known-answer vectors for the AES power-on self-test.
// Expected ciphertexts are only compiled with AES_SELFTEST_CIPHER_CHECK_EN.
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        WAIT_ENC  = 3'd2,
        CHECK_ENC = 3'd3,
        WAIT_DEC  = 3'd4,
        CHECK_DEC = 3'd5,
        DONE      = 3'd6
    } state_t;

    localparam logic [1:0] KSZ_128 = 2'd1;
    localparam logic [1:0] KSZ_192 = 2'd2;
    localparam logic [1:0] KSZ_256 = 2'd3;

    localparam logic [127:0] KAT_PT = 128'h00112233445566778899aabbccddeeff;

    // Keys are MSB-aligned in the 256-bit core key bus, unused LSBs zero.
    localparam logic [255:0] KAT_KEY_128 =
        256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000;
    localparam logic [255:0] KAT_KEY_192 =
        256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000;
    localparam logic [255:0] KAT_KEY_256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

`ifdef AES_SELFTEST_CIPHER_CHECK_EN
    localparam logic [127:0] KAT_CT_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KAT_CT_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] KAT_CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;
`endif

    function automatic logic [1:0] ksz_of(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/aes_kat_rom.sv
// Combinational known-answer vector table indexed by key-size index k.
// Expected-ciphertext port exists only with AES_SELFTEST_CIPHER_CHECK_EN.
module aes_kat_rom
    import aes_pkg::*;
(
    input  logic [1:0]   k,
`ifdef AES_SELFTEST_CIPHER_CHECK_EN
    output logic [127:0] ct,
`endif
    output logic [255:0] key
);

    always_comb begin
        key = '0;
        case (k)
            2'd0:    key = KAT_KEY_128;
            2'd1:    key = KAT_KEY_192;
            2'd2:    key = KAT_KEY_256;
            default: key = '0;
        endcase
    end

`ifdef AES_SELFTEST_CIPHER_CHECK_EN
    always_comb begin
        ct = '0;
        case (k)
            2'd0:    ct = KAT_CT_128;
            2'd1:    ct = KAT_CT_192;
            2'd2:    ct = KAT_CT_256;
            default: ct = '0;
        endcase
    end
`endif

endmodule

// File: rtl/aes_selftest_ctrl.sv
// Encrypt/decrypt round-trip self-test of a shared AES core for 128/192/256-bit keys.
// Define AES_SELFTEST_CIPHER_CHECK_EN to also compare ciphertext against FIPS-197 vectors.
module aes_selftest_ctrl
    import aes_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [127:0] core_in,
    output logic [255:0] core_key,
    output logic [1:0]   core_ksz,
    output logic         core_dec,
    input  logic [127:0] core_out,
    output logic         busy,
    output logic         done,
    output logic         fail,
    output logic         led1,
    output logic         led2,
    output logic         led3
);

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t       state;
    logic [1:0]   k;
    logic [3:0]   cnt;
    logic [127:0] ct_q;
    logic         enc_ok;
    logic [2:0]   led_q;

    logic [1:0]   rom_k;
    logic [255:0] rom_key;
    logic         enc_match;
    logic         dec_match;
    logic         pass;

    // Core inputs are loaded on entry to LOAD, so the ROM looks ahead to k+1 in CHECK_DEC.
    assign rom_k = (state == CHECK_DEC) ? k + 2'd1 : k;

`ifdef AES_SELFTEST_CIPHER_CHECK_EN
    logic [127:0] rom_ct;

    aes_kat_rom u_kat_rom (
        .k   (rom_k),
        .ct  (rom_ct),
        .key (rom_key)
    );

    assign enc_match = (core_out == rom_ct);
`else
    aes_kat_rom u_kat_rom (
        .k   (rom_k),
        .key (rom_key)
    );

    assign enc_match = 1'b1;
`endif

    assign dec_match = (core_out == KAT_PT);
    assign pass      = enc_ok & dec_match;

    assign led1 = led_q[0];
    assign led2 = led_q[1];
    assign led3 = led_q[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            k        <= 2'd0;
            cnt      <= 4'd0;
            ct_q     <= '0;
            enc_ok   <= 1'b0;
            core_in  <= '0;
            core_key <= '0;
            core_ksz <= KSZ_128;
            core_dec <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fail     <= 1'b0;
            led_q    <= 3'b000;
        end else if (state == IDLE) begin
            if (en) begin
                state    <= LOAD;
                k        <= 2'd0;
                core_in  <= KAT_PT;
                core_key <= rom_key;
                core_ksz <= ksz_of(rom_k);
                core_dec <= 1'b0;
                busy     <= 1'b1;
            end
        end else if (state != DONE && en) begin
            // Dropping en in a busy state freezes everything, including the core inputs.
            case (state)
                LOAD: begin
                    cnt   <= 4'd0;
                    state <= WAIT_ENC;
                end
                WAIT_ENC: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= 4'd0;
                        state <= CHECK_ENC;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                CHECK_ENC: begin
                    ct_q     <= core_out;
                    enc_ok   <= enc_match;
                    core_in  <= core_out;
                    core_dec <= 1'b1;
                    cnt      <= 4'd0;
                    state    <= WAIT_DEC;
                end
                WAIT_DEC: begin
                    core_in <= ct_q;
                    if (cnt == CNT_LAST) begin
                        cnt   <= 4'd0;
                        state <= CHECK_DEC;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                CHECK_DEC: begin
                    led_q[k] <= pass;
                    if (!pass) begin
                        fail <= 1'b1;
                    end
                    if (k == 2'd2) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        k        <= k + 2'd1;
                        core_in  <= KAT_PT;
                        core_key <= rom_key;
                        core_ksz <= ksz_of(rom_k);
                        core_dec <= 1'b0;
                        state    <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_selftest_ctrl.sv
// Scoreboard bench for aes_selftest_ctrl: KAT-table core model, default and SETTLE_CYCLES=1 instances.
module tb_aes_selftest_ctrl;

    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K128 =
        256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000;
    localparam logic [255:0] K192 =
        256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000;
    localparam logic [255:0] K256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    localparam int M_OK     = 0;
    localparam int M_DEC192 = 1;
    localparam int M_BADCT  = 2;

    typedef struct {
        int         cyc;
        logic [2:0] led;
        logic       fail;
    } exp_t;

    exp_t sb[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    int   mode = M_OK;
    int   lat  = 0;
    int   sel  = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [127:0] cin0, cin1, cout0, cout1;
    logic [255:0] ckey0, ckey1;
    logic [1:0]   cksz0, cksz1;
    logic         cdec0, cdec1;
    logic         busy0, busy1, done0, done1, fail0, fail1;
    logic         l10, l20, l30, l11, l21, l31;
    int           age0 = 0, age1 = 0;
    logic [386:0] prev0 = '0, prev1 = '0;

    always #5 clk = ~clk;

    aes_selftest_ctrl #(.SETTLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .en(en),
        .core_in(cin0), .core_key(ckey0), .core_ksz(cksz0), .core_dec(cdec0),
        .core_out(cout0), .busy(busy0), .done(done0), .fail(fail0),
        .led1(l10), .led2(l20), .led3(l30)
    );

    aes_selftest_ctrl #(.SETTLE_CYCLES(1)) dut_s1 (
        .clk(clk), .rst(rst), .en(en),
        .core_in(cin1), .core_key(ckey1), .core_ksz(cksz1), .core_dec(cdec1),
        .core_out(cout1), .busy(busy1), .done(done1), .fail(fail1),
        .led1(l11), .led2(l21), .led3(l31)
    );

    // Core model: correct only at the KAT points, and only once inputs have been stable for lat cycles.
    function automatic logic [127:0] core_model(input logic [127:0] din, input logic [255:0] key,
                                                input logic [1:0] ksz, input logic dec,
                                                input int m, input bit ready);
        logic [255:0] k_exp;
        logic [127:0] ct;
        logic [127:0] r;
        case (ksz)
            2'd1:    begin k_exp = K128; ct = CT128; end
            2'd2:    begin k_exp = K192; ct = CT192; end
            2'd3:    begin k_exp = K256; ct = CT256; end
            default: begin k_exp = '1;   ct = '0;    end
        endcase
        if (m == M_BADCT && ksz == 2'd1) ct = ct ^ 128'h80;
        if (!ready) return '0;
        if (key != k_exp) return ~din;
        if (!dec) return (din == PT) ? ct : ~din;
        r = (din == ct) ? PT : ~din;
        if (m == M_DEC192 && ksz == 2'd2) r[0] = ~r[0];
        return r;
    endfunction

    always @(negedge clk) begin
        if ({cin0, ckey0, cksz0, cdec0} != prev0) age0 <= 0;
        else if (age0 < 1000) age0 <= age0 + 1;
        prev0 <= {cin0, ckey0, cksz0, cdec0};
        if ({cin1, ckey1, cksz1, cdec1} != prev1) age1 <= 0;
        else if (age1 < 1000) age1 <= age1 + 1;
        prev1 <= {cin1, ckey1, cksz1, cdec1};
    end

    always_comb begin
        cout0 = core_model(cin0, ckey0, cksz0, cdec0, mode, age0 >= lat);
        cout1 = core_model(cin1, ckey1, cksz1, cdec1, mode, age1 >= lat);
    end

    logic [127:0] o_in;
    logic [255:0] o_key;
    logic [1:0]   o_ksz;
    logic         o_dec, o_busy, o_done, o_fail;
    logic [2:0]   o_led;

    always_comb begin
        o_in   = (sel == 1) ? cin1  : cin0;
        o_key  = (sel == 1) ? ckey1 : ckey0;
        o_ksz  = (sel == 1) ? cksz1 : cksz0;
        o_dec  = (sel == 1) ? cdec1 : cdec0;
        o_busy = (sel == 1) ? busy1 : busy0;
        o_done = (sel == 1) ? done1 : done0;
        o_fail = (sel == 1) ? fail1 : fail0;
        o_led  = (sel == 1) ? {l31, l21, l11} : {l30, l20, l10};
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".busy"}, o_busy, 1'b0);
        chk({tag, ".done"}, o_done, 1'b0);
        chk({tag, ".fail"}, o_fail, 1'b0);
        chk({tag, ".leds"}, o_led, 3'b000);
        chk({tag, ".core_in"}, o_in, 128'h0);
        chk({tag, ".core_key"}, o_key, 256'h0);
        chk({tag, ".core_ksz"}, o_ksz, 2'd1);
        chk({tag, ".core_dec"}, o_dec, 1'b0);
    endtask

    // pause_at: en low for the five edges after that cycle; rst_at: reset edge, then restart.
    task automatic run(input string name, input int s, input int m, input int l,
                       input int exp_cyc, input logic [2:0] exp_led, input logic exp_fail,
                       input int pause_at, input int rst_at);
        exp_t r;
        int   cyc;
        bit   got;
        bit   in_rst;
        bit   rst_done;
        sel = s; mode = m; lat = l;
        @(negedge clk);
        rst = 1'b1; en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk_reset({name, ".rst"});
        sb.push_back('{cyc: exp_cyc, led: exp_led, fail: exp_fail});
        en = 1'b1;
        cyc = -1; got = 0; in_rst = 0; rst_done = 0;
        for (int t = 0; t < 80 && !got; t++) begin
            @(posedge clk);
            cyc++;
            #1;
            if (in_rst) begin
                chk_reset({name, ".midrst"});
                rst = 1'b0;
                in_rst = 0;
                cyc = -1;
            end else if (o_done) begin
                r = sb.pop_front();
                chk({name, ".done_cycle"}, cyc, r.cyc);
                chk({name, ".leds"}, o_led, r.led);
                chk({name, ".fail"}, o_fail, r.fail);
                chk({name, ".busy_at_done"}, o_busy, 1'b0);
                got = 1;
            end else begin
                chk({name, ".busy"}, o_busy, 1'b1);
                if (cyc == 0) begin
                    chk({name, ".load_in"}, o_in, PT);
                    chk({name, ".load_key"}, o_key, K128);
                    chk({name, ".load_ksz"}, o_ksz, 2'd1);
                    chk({name, ".load_dec"}, o_dec, 1'b0);
                end
                if (pause_at >= 0 && cyc > pause_at && cyc <= pause_at + 5) begin
                    chk({name, ".frz_in"}, o_in, CT192);
                    chk({name, ".frz_key"}, o_key, K192);
                    chk({name, ".frz_ksz"}, o_ksz, 2'd2);
                    chk({name, ".frz_dec"}, o_dec, 1'b1);
                end
            end
            if (!got) begin
                @(negedge clk);
                if (!rst_done && rst_at >= 0 && cyc == rst_at - 1) begin
                    rst = 1'b1;
                    in_rst = 1;
                    rst_done = 1;
                end
                if (pause_at >= 0 && cyc == pause_at) en = 1'b0;
                if (pause_at >= 0 && cyc == pause_at + 5) en = 1'b1;
            end
        end
        if (!got) begin
            chk({name, ".timeout"}, 1'b0, 1'b1);
            void'(sb.pop_front());
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);

        run("ok", 0, M_OK, 0, 33, 3'b111, 1'b0, -1, -1);
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("hold.done", o_done, 1'b1);
        chk("hold.leds", o_led, 3'b111);
        @(negedge clk);
        en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("hold.done_en", o_done, 1'b1);
        chk("hold.busy_en", o_busy, 1'b0);

        run("dec192", 0, M_DEC192, 0, 33, 3'b101, 1'b1, -1, -1);
`ifdef AES_SELFTEST_CIPHER_CHECK_EN
        run("badct", 0, M_BADCT, 0, 33, 3'b110, 1'b1, -1, -1);
`else
        run("badct", 0, M_BADCT, 0, 33, 3'b111, 1'b0, -1, -1);
`endif
        run("pause", 0, M_OK, 0, 38, 3'b111, 1'b0, 18, -1);
        run("midrst", 0, M_OK, 0, 33, 3'b111, 1'b0, -1, 20);
        run("s1", 1, M_OK, 0, 15, 3'b111, 1'b0, -1, -1);
        run("s1_slow", 1, M_OK, 2, 15, 3'b000, 1'b1, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
